// File: rtl/zint_pkg.sv
// Shared constants for the ZX-bus interrupt scheduler: FSM encoding, source
// indices and counter width.
package zint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } zint_state_t;

  localparam int SRC_W5300 = 0;
  localparam int SRC_SL811 = 1;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/zint_sync.sv
// Two-flop synchronizer for an asynchronous, already active-high request line.
module zint_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/zint_sched.sv
// ZX-bus /INT scheduler for the W5300 and SL811 sources: fixed-length pulse plus hold-off gap.
// Define ZINT_RR_EN for round-robin arbitration; otherwise W5300 has fixed priority.
module zint_sched
  import zint_pkg::*;
#(
  parameter int INT_LEN = 32,
  parameter int INT_GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w5300_int_n,
  input  logic       sl811_intrq,
  input  logic       ena_w5300_int,
  input  logic       ena_sl811_int,
  input  logic       ena_zxbus_int,
  input  logic       ack_stb,
  input  logic [1:0] ack_mask,
  output logic       zint_oe,
  output logic [1:0] pending,
  output logic       cur_src,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(INT_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(INT_GAP - 1);

  logic [1:0]       w_req;
  logic [1:0]       w_rise;
  logic [1:0]       w_en;
  logic [1:0]       w_clr;
  logic [1:0]       w_pend_nxt;
  logic [1:0]       r_req_d;
  logic [1:0]       r_pend;

  zint_state_t      r_state;
  zint_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_cur;
  logic             w_cur_nxt;
`ifdef ZINT_RR_EN
  logic             r_rr;
  logic             w_rr_nxt;
`endif

  zint_sync u_sync_w5300 (
    .clk (clk),
    .rst (rst),
    .i_d (~w5300_int_n),
    .o_q (w_req[SRC_W5300])
  );

  zint_sync u_sync_sl811 (
    .clk (clk),
    .rst (rst),
    .i_d (sl811_intrq),
    .o_q (w_req[SRC_SL811])
  );

  assign w_rise = w_req & ~r_req_d;
  assign w_en   = {ena_sl811_int, ena_w5300_int};
  assign w_clr  = ack_stb ? ack_mask : 2'b00;
  // Set beats ack; a disabled source is forced clear regardless of events.
  assign w_pend_nxt = ((r_pend & ~w_clr) | w_rise) & w_en;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
`ifdef ZINT_RR_EN
    w_rr_nxt    = r_rr;
`endif
    case (r_state)
      IDLE: begin
        if (ena_zxbus_int && (w_pend_nxt != 2'b00)) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = LEN_M1;
          if (w_pend_nxt == 2'b11) begin
`ifdef ZINT_RR_EN
            w_cur_nxt = r_rr;
            w_rr_nxt  = ~r_rr;
`else
            w_cur_nxt = 1'(SRC_W5300);
`endif
          end else begin
            w_cur_nxt = w_pend_nxt[SRC_SL811];
          end
        end
      end
      PULSE: begin
        if (!ena_zxbus_int || (r_cnt == '0)) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = GAP_M1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cur   <= 1'b0;
      r_req_d <= 2'b00;
      r_pend  <= 2'b00;
`ifdef ZINT_RR_EN
      r_rr    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cur   <= w_cur_nxt;
      r_req_d <= w_req;
      r_pend  <= w_pend_nxt;
`ifdef ZINT_RR_EN
      r_rr    <= w_rr_nxt;
`endif
    end
  end

  assign zint_oe = (r_state == PULSE);
  assign busy    = (r_state != IDLE);
  assign pending = r_pend;
  assign cur_src = r_cur;

endmodule

// File: tb/tb_zint_sched.sv
// Table-driven scoreboard bench for zint_sched (default and INT_LEN=INT_GAP=1 instances).
module tb_zint_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w5300_int_n = 1'b1;
  logic       sl811_intrq = 1'b0;
  logic       ena_w5300_int = 1'b1;
  logic       ena_sl811_int = 1'b1;
  logic       ena_zxbus_int = 1'b1;
  logic       ack_stb = 1'b0;
  logic [1:0] ack_mask = 2'b00;
  logic       zint_oe, cur_src, busy;
  logic [1:0] pending;
  logic       zint_oe1, cur_src1, busy1;
  logic [1:0] pending1;

  always #5 clk = ~clk;

  zint_sched u_dut (
    .clk(clk), .rst(rst), .w5300_int_n(w5300_int_n), .sl811_intrq(sl811_intrq),
    .ena_w5300_int(ena_w5300_int), .ena_sl811_int(ena_sl811_int),
    .ena_zxbus_int(ena_zxbus_int), .ack_stb(ack_stb), .ack_mask(ack_mask),
    .zint_oe(zint_oe), .pending(pending), .cur_src(cur_src), .busy(busy)
  );

  zint_sched #(.INT_LEN(1), .INT_GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .w5300_int_n(w5300_int_n), .sl811_intrq(sl811_intrq),
    .ena_w5300_int(ena_w5300_int), .ena_sl811_int(ena_sl811_int),
    .ena_zxbus_int(ena_zxbus_int), .ack_stb(ack_stb), .ack_mask(ack_mask),
    .zint_oe(zint_oe1), .pending(pending1), .cur_src(cur_src1), .busy(busy1)
  );

  localparam int K_STIM = 0, K_EXP = 1;
  localparam int S_WN = 0, S_SL = 1, S_ENW = 2, S_ENS = 3, S_ENZ = 4, S_ACK = 5, S_RST = 6;
  localparam int O_OE = 0, O_PEND = 1, O_BUSY = 2, O_CUR = 3, O_OE1 = 4, O_BUSY1 = 5;

  typedef struct {
    int scn;
    int kind;
    int cyc;
    int sig;
    int val;
  } vec_t;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } ev_t;

  vec_t  tbl[$];
  ev_t   stim_q[$];
  ev_t   exp_q[$];
  int    cyc;
  int    nchk = 0;
  int    nerr = 0;
  string onames[6] = '{"zint_oe", "pending", "busy", "cur_src", "zint_oe_len1", "busy_len1"};

  function automatic void add(int scn, int kind, int c, int sig, int val);
    vec_t v;
    v.scn = scn; v.kind = kind; v.cyc = c; v.sig = sig; v.val = val;
    tbl.push_back(v);
  endfunction

  function automatic void push_stim(ev_t e);
    int i = 0;
    while (i < stim_q.size() && stim_q[i].cyc <= e.cyc) i++;
    stim_q.insert(i, e);
  endfunction

  function automatic void push_exp(ev_t e);
    int i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= e.cyc) i++;
    exp_q.insert(i, e);
  endfunction

  function automatic int get_out(int s);
    case (s)
      O_OE:    return int'(zint_oe);
      O_PEND:  return int'(pending);
      O_BUSY:  return int'(busy);
      O_CUR:   return int'(cur_src);
      O_OE1:   return int'(zint_oe1);
      O_BUSY1: return int'(busy1);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input int scn, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL scn%0d %s cyc=%0d got=%0d want=%0d", scn, nm, cyc, act, exp);
    end
  endtask

  task automatic apply(input ev_t e);
    case (e.sig)
      S_WN:  w5300_int_n = e.val[0];
      S_SL:  sl811_intrq = e.val[0];
      S_ENW: ena_w5300_int = e.val[0];
      S_ENS: ena_sl811_int = e.val[0];
      S_ENZ: ena_zxbus_int = e.val[0];
      S_ACK: begin ack_stb = 1'b1; ack_mask = e.val[1:0]; end
      S_RST: rst = e.val[0];
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_scn(input int scn, input int ncyc);
    ev_t e;
    rst = 1'b1; w5300_int_n = 1'b1; sl811_intrq = 1'b0;
    ena_w5300_int = 1'b1; ena_sl811_int = 1'b1; ena_zxbus_int = 1'b1;
    ack_stb = 1'b0; ack_mask = 2'b00;
    repeat (3) tick();
    for (int s = 0; s < 6; s++) chk({"reset_", onames[s]}, scn, get_out(s), 0);
    rst = 1'b0;
    stim_q.delete();
    exp_q.delete();
    foreach (tbl[i]) begin
      if (tbl[i].scn == scn) begin
        e.cyc = tbl[i].cyc; e.sig = tbl[i].sig; e.val = tbl[i].val;
        if (tbl[i].kind == K_STIM) push_stim(e);
        else push_exp(e);
      end
    end
    cyc = 0;
    while (stim_q.size() > 0 && stim_q[0].cyc == 0) apply(stim_q.pop_front());
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      ack_stb = 1'b0;
      ack_mask = 2'b00;
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk(onames[e.sig], scn, get_out(e.sig), e.val);
      end
      while (stim_q.size() > 0 && stim_q[0].cyc == cyc) apply(stim_q.pop_front());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({"unreached_", onames[e.sig]}, scn, -1, e.val);
    end
  endtask

  initial begin
    // 1: single W5300 event, no ack -> repeat pulse; LEN/GAP=1 instance alongside
    add(1, K_STIM, 10, S_WN, 0);
    add(1, K_EXP, 12, O_PEND, 0);  add(1, K_EXP, 12, O_OE, 0);
    add(1, K_EXP, 13, O_PEND, 1);  add(1, K_EXP, 13, O_OE, 1);   add(1, K_EXP, 13, O_CUR, 0);
    add(1, K_EXP, 13, O_OE1, 1);   add(1, K_EXP, 14, O_OE1, 0);  add(1, K_EXP, 14, O_BUSY1, 1);
    add(1, K_EXP, 15, O_BUSY1, 0); add(1, K_EXP, 16, O_OE1, 1);
    add(1, K_EXP, 44, O_OE, 1);    add(1, K_EXP, 45, O_OE, 0);   add(1, K_EXP, 45, O_BUSY, 1);
    add(1, K_EXP, 60, O_BUSY, 1);  add(1, K_EXP, 61, O_BUSY, 0); add(1, K_EXP, 61, O_OE, 0);
    add(1, K_EXP, 62, O_OE, 1);    add(1, K_EXP, 62, O_PEND, 1);
    // 2: ack mid-pulse; pulse completes, no repeat
    add(2, K_STIM, 10, S_WN, 0);   add(2, K_STIM, 20, S_ACK, 1);
    add(2, K_EXP, 13, O_OE, 1);    add(2, K_EXP, 20, O_PEND, 1); add(2, K_EXP, 21, O_PEND, 0);
    add(2, K_EXP, 44, O_OE, 1);    add(2, K_EXP, 45, O_OE, 0);   add(2, K_EXP, 61, O_BUSY, 0);
    add(2, K_EXP, 62, O_OE, 0);    add(2, K_EXP, 70, O_BUSY, 0);
    // 3: both sources, ack W5300 -> second pulse for SL811
    add(3, K_STIM, 10, S_WN, 0);   add(3, K_STIM, 10, S_SL, 1);  add(3, K_STIM, 30, S_ACK, 1);
    add(3, K_EXP, 13, O_PEND, 3);  add(3, K_EXP, 13, O_CUR, 0);  add(3, K_EXP, 31, O_PEND, 2);
    add(3, K_EXP, 62, O_OE, 1);    add(3, K_EXP, 62, O_CUR, 1);
    // 4: both sources, no acks -> arbitration across three pulses
    add(4, K_STIM, 10, S_WN, 0);   add(4, K_STIM, 10, S_SL, 1);
    add(4, K_EXP, 13, O_CUR, 0);   add(4, K_EXP, 62, O_OE, 1);
`ifdef ZINT_RR_EN
    add(4, K_EXP, 62, O_CUR, 1);
`else
    add(4, K_EXP, 62, O_CUR, 0);
`endif
    add(4, K_EXP, 111, O_OE, 1);   add(4, K_EXP, 111, O_CUR, 0);
    // 5: master enable dropped five cycles into the pulse
    add(5, K_STIM, 10, S_WN, 0);   add(5, K_STIM, 17, S_ENZ, 0);
    add(5, K_EXP, 17, O_OE, 1);    add(5, K_EXP, 18, O_OE, 0);   add(5, K_EXP, 18, O_BUSY, 1);
    add(5, K_EXP, 18, O_PEND, 1);  add(5, K_EXP, 33, O_BUSY, 1); add(5, K_EXP, 34, O_BUSY, 0);
    add(5, K_EXP, 34, O_PEND, 1);  add(5, K_EXP, 40, O_OE, 0);
    // 6: SL811 disabled while toggling, then enabled while held high
    add(6, K_STIM, 0, S_ENS, 0);   add(6, K_STIM, 5, S_SL, 1);   add(6, K_STIM, 10, S_SL, 0);
    add(6, K_STIM, 15, S_SL, 1);   add(6, K_STIM, 25, S_ENS, 1);
    add(6, K_EXP, 12, O_PEND, 0);  add(6, K_EXP, 20, O_PEND, 0); add(6, K_EXP, 20, O_OE, 0);
    add(6, K_EXP, 30, O_PEND, 0);  add(6, K_EXP, 35, O_OE, 0);   add(6, K_EXP, 35, O_BUSY, 0);
    // 7: reset in the middle of an SL811 pulse
    add(7, K_STIM, 10, S_SL, 1);   add(7, K_STIM, 32, S_RST, 1); add(7, K_STIM, 32, S_SL, 0);
    add(7, K_STIM, 34, S_RST, 0);
    add(7, K_EXP, 13, O_CUR, 1);   add(7, K_EXP, 32, O_OE, 1);   add(7, K_EXP, 32, O_PEND, 2);
    add(7, K_EXP, 33, O_OE, 0);    add(7, K_EXP, 33, O_PEND, 0); add(7, K_EXP, 33, O_BUSY, 0);
    add(7, K_EXP, 33, O_CUR, 0);   add(7, K_EXP, 36, O_BUSY, 0); add(7, K_EXP, 40, O_OE, 0);
    add(7, K_EXP, 40, O_PEND, 0);

    run_scn(1, 65);
    run_scn(2, 72);
    run_scn(3, 65);
    run_scn(4, 115);
    run_scn(5, 42);
    run_scn(6, 38);
    run_scn(7, 42);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
